// File: rtl/output_argmax.sv
// output_argmax: sequential argmax over a captured vector of neuron outputs.
// One element is compared per cycle against a running maximum; the winning
// index and value are published with a one-cycle strobe. A level-held valid
// yields a single result and must drop before the next request is accepted.

// Single strictly-greater comparator, signed or unsigned by parameter.
module output_argmax_cmp #(
    parameter int dataWidth  = 8,
    parameter bit signedData = 1'b1
) (
    input  logic [dataWidth-1:0] candidate,
    input  logic [dataWidth-1:0] current,
    output logic                 greater
);
    generate
        if (signedData) begin : gSigned
            // Two's complement ordering.
            assign greater = $signed(candidate) > $signed(current);
        end else begin : gUnsigned
            // Plain magnitude ordering.
            assign greater = candidate > current;
        end
    endgenerate
endmodule

module output_argmax #(
    parameter int dataWidth  = 8,
    parameter int numNeurons = 10,
    parameter bit signedData = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [dataWidth*numNeurons-1:0] argIn,
    input  logic                            argInValid,
    output logic                            argReady,
    output logic [$clog2(numNeurons)-1:0]   argOut,
    output logic [dataWidth-1:0]            maxValue,
    output logic                            argOutValid
);
    localparam int idxW = $clog2(numNeurons);
    localparam int cntW = $clog2(numNeurons + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] REARM = 2'd3;

    localparam logic [cntW-1:0] lastCount = cntW'(numNeurons - 1);

    logic [1:0]                                state;
    logic [numNeurons-1:0][dataWidth-1:0]      argReg;
    logic [cntW-1:0]                           counter;
    logic [dataWidth-1:0]                      runMax;
    logic [idxW-1:0]                           runIdx;

    logic [idxW-1:0]      scanIdx;
    logic [dataWidth-1:0] scanElem;
    logic                 scanGreater;
    logic [dataWidth-1:0] nextMax;
    logic [idxW-1:0]      nextIdx;

    // Counter never exceeds numNeurons-1, so truncating to the index width is lossless.
    assign scanIdx  = idxW'(counter);
    assign scanElem = argReg[scanIdx];

    output_argmax_cmp #(
        .dataWidth  (dataWidth),
        .signedData (signedData)
    ) uCmp (
        .candidate (scanElem),
        .current   (runMax),
        .greater   (scanGreater)
    );

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        nextMax = runMax;
        nextIdx = runIdx;
        if (scanGreater) begin
            nextMax = scanElem;
            nextIdx = scanIdx;
        end
    end

    // Ready is a pure decode of the state.
    assign argReady = (state == IDLE);

    // Control FSM, capture register, running max and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            argReg      <= '0;
            counter     <= '0;
            runMax      <= '0;
            runIdx      <= '0;
            argOut      <= '0;
            maxValue    <= '0;
            argOutValid <= 1'b0;
        end else begin
            argOutValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (argInValid) begin
                        argReg  <= argIn;
                        runMax  <= argIn[dataWidth-1:0];
                        runIdx  <= '0;
                        counter <= cntW'(1);
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    runMax <= nextMax;
                    runIdx <= nextIdx;
                    if (counter == lastCount) begin
                        // Last element: publish the final winner directly.
                        argOut      <= nextIdx;
                        maxValue    <= nextMax;
                        argOutValid <= 1'b1;
                        counter     <= '0;
                        state       <= DONE;
                    end else begin
                        counter <= counter + cntW'(1);
                    end
                end
                DONE: begin
                    state <= argInValid ? REARM : IDLE;
                end
                default: begin
                    // REARM: wait for the requester to drop a held valid.
                    if (!argInValid) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_output_argmax.sv
// Scoreboard bench for output_argmax: a signed and an unsigned instance share
// the stimulus; the driver queues hand-computed results per instance and two
// monitors pop and compare whenever a result strobe appears.
module tb_output_argmax;
    localparam int DW = 8;
    localparam int NN = 10;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [DW*NN-1:0] argIn = '0;
    logic             argInValid = 1'b0;

    logic             readyS, validS, readyU, validU;
    logic [3:0]       outS, outU;
    logic [7:0]       maxS, maxU;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t qS[$];
    exp_t qU[$];

    output_argmax #(.dataWidth(DW), .numNeurons(NN), .signedData(1'b1)) dutS (
        .clk(clk), .reset(reset), .argIn(argIn), .argInValid(argInValid),
        .argReady(readyS), .argOut(outS), .maxValue(maxS), .argOutValid(validS)
    );

    output_argmax #(.dataWidth(DW), .numNeurons(NN), .signedData(1'b0)) dutU (
        .clk(clk), .reset(reset), .argIn(argIn), .argInValid(argInValid),
        .argReady(readyU), .argOut(outU), .maxValue(maxU), .argOutValid(validU)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc equals the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW*NN-1:0] mk(input logic [7:0] base,
                                            input int k1, input logic [7:0] v1,
                                            input int k2, input logic [7:0] v2);
        logic [DW*NN-1:0] v;
        for (int k = 0; k < NN; k++) v[k*DW +: DW] = base;
        if (k1 >= 0) v[k1*DW +: DW] = v1;
        if (k2 >= 0) v[k2*DW +: DW] = v2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Signed-instance monitor.
    always @(negedge clk) begin
        exp_t e;
        if (validS) begin
            if (qS.size() == 0) begin
                errors++;
                $display("FAIL s_unexpected_strobe actual=1 required=0 at cyc %0d", cyc);
            end else begin
                e = qS.pop_front();
                checks++;
                if (outS !== e.idx || maxS !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL s_result actual idx=%0d val=%0h cyc=%0d required idx=%0d val=%0h cyc=%0d",
                             outS, maxS, cyc, e.idx, e.val, e.cyc);
                end
            end
        end
    end

    // Unsigned-instance monitor.
    always @(negedge clk) begin
        exp_t e;
        if (validU) begin
            if (qU.size() == 0) begin
                errors++;
                $display("FAIL u_unexpected_strobe actual=1 required=0 at cyc %0d", cyc);
            end else begin
                e = qU.pop_front();
                checks++;
                if (outU !== e.idx || maxU !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL u_result actual idx=%0d val=%0h cyc=%0d required idx=%0d val=%0h cyc=%0d",
                             outU, maxU, cyc, e.idx, e.val, e.cyc);
                end
            end
        end
    end

    // Called at a falling edge; the acceptance edge T is the next rising edge.
    // The strobe is high in the cycle ending at edge T+NN, i.e. seen at the
    // falling edge after rising edge T+NN-1.
    task automatic issue(input logic [DW*NN-1:0] vec, input bit expect_result,
                         input logic [3:0] is, input logic [7:0] vs,
                         input logic [3:0] iu, input logic [7:0] vu,
                         output int t);
        exp_t e;
        check("ready_before_req", {31'd0, readyS & readyU}, 32'd1);
        argIn      = vec;
        argInValid = 1'b1;
        t = cyc + 1;
        if (expect_result) begin
            e.idx = is; e.val = vs; e.cyc = t + NN - 1; qS.push_back(e);
            e.idx = iu; e.val = vu; e.cyc = t + NN - 1; qU.push_back(e);
        end
    endtask

    task automatic pulse(input logic [DW*NN-1:0] vec,
                         input logic [3:0] is, input logic [7:0] vs,
                         input logic [3:0] iu, input logic [7:0] vu);
        int t;
        issue(vec, 1'b1, is, vs, iu, vu, t);
        @(negedge clk);
        argInValid = 1'b0;
        repeat (NN + 2) @(negedge clk);
    endtask

    initial begin
        int t;
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, validS | validU}, 32'd0);
        check("rst_argout", {24'd0, outS, outU}, 32'd0);
        check("rst_max", {16'd0, maxS, maxU}, 32'd0);
        check("rst_ready", {31'd0, readyS & readyU}, 32'd1);
        reset = 1'b1;

        // Single peak, accepted on the first edge after reset release.
        pulse(mk(8'h10, 7, 8'h50, -1, 8'h00), 4'd7, 8'h50, 4'd7, 8'h50);
        // Tie keeps the lowest index.
        pulse(mk(8'h05, 2, 8'h20, 5, 8'h20), 4'd2, 8'h20, 4'd2, 8'h20);
        // Negative values.
        pulse(mk(8'h80, 4, 8'hFF, -1, 8'h00), 4'd4, 8'hFF, 4'd4, 8'hFF);
        pulse(mk(8'h80, 0, 8'hFF, -1, 8'h00), 4'd0, 8'hFF, 4'd0, 8'hFF);
        // 0x7F beats 0x80 only when signed.
        pulse(mk(8'h80, 3, 8'h7F, -1, 8'h00), 4'd3, 8'h7F, 4'd0, 8'h80);

        // argIn altered during the scan must not affect the result.
        issue(mk(8'h01, 9, 8'h30, -1, 8'h00), 1'b1, 4'd9, 8'h30, 4'd9, 8'h30, t);
        @(negedge clk);
        argInValid = 1'b0;
        repeat (2) @(negedge clk);
        argIn = mk(8'h7F, -1, 8'h00, -1, 8'h00);
        repeat (NN) @(negedge clk);

        // Level-held valid: one result, ready low until valid drops.
        begin
            bit lowOk;
            lowOk = 1'b1;
            issue(mk(8'h00, 0, 8'h11, -1, 8'h00), 1'b1, 4'd0, 8'h11, 4'd0, 8'h11, t);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (readyS !== 1'b0 || readyU !== 1'b0) lowOk = 1'b0;
            end
            argInValid = 1'b0;
            check("held_ready_low", {31'd0, lowOk}, 32'd1);
            @(negedge clk);
            check("held_ready_back", {31'd0, readyS & readyU}, 32'd1);
        end
        pulse(mk(8'hF0, 6, 8'hF8, -1, 8'h00), 4'd6, 8'hF8, 4'd6, 8'hF8);

        // Reset during the scan aborts without a strobe.
        issue(mk(8'h10, 7, 8'h50, -1, 8'h00), 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, t);
        @(negedge clk);
        argInValid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'd0, validS | validU}, 32'd0);
        check("midrst_argout", {24'd0, outS, outU}, 32'd0);
        check("midrst_max", {16'd0, maxS, maxU}, 32'd0);
        check("midrst_ready", {31'd0, readyS & readyU}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (NN) @(negedge clk);
        check("midrst_quiet", {31'd0, validS | validU}, 32'd0);
        pulse(mk(8'h80, 3, 8'h7F, -1, 8'h00), 4'd3, 8'h7F, 4'd0, 8'h80);

        repeat (4) @(negedge clk);
        check("queues_drained", qS.size() + qU.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
